// File: rtl/serial_char_deserializer.sv
// Serial-to-parallel character deserializer with a valid/ready holding register and overrun flag.
// Optional PARITY_CHECK_EN: appends one parity bit per frame and adds the parity_err output.
module serial_char_deserializer #(
    parameter int WIDTH     = 7,
    parameter bit MSB_FIRST = 1'b1
`ifdef PARITY_CHECK_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             data_valid,
    input  logic             frame_clr,
    input  logic             out_ready,
    output logic [WIDTH-1:0] char_out,
    output logic             char_valid,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

`ifdef PARITY_CHECK_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int             CW   = $clog2(FL);
    localparam logic [CW-1:0]  LAST = CW'(FL - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] new_char;
    logic             done;
    logic             hold_free;
`ifdef PARITY_CHECK_EN
    logic             new_perr;
`endif

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) begin
            shreg_next = {shreg[WIDTH-2:0], data};
        end else begin
            shreg_next = {data, shreg[WIDTH-1:1]};
        end
        done      = data_valid && !frame_clr && (cnt == LAST);
        hold_free = !char_valid || out_ready;
`ifdef PARITY_CHECK_EN
        // The final bit of the frame is the parity bit; data bits are already in shreg.
        new_char  = shreg;
        new_perr  = ((^shreg) ^ data) != PARITY_ODD;
`else
        new_char  = shreg_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            shreg      <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;

            if (frame_clr) begin
                cnt   <= '0;
                shreg <= '0;
            end else if (data_valid) begin
                if (cnt == LAST) begin
                    cnt   <= '0;
                    shreg <= '0;
                end else begin
                    cnt   <= cnt + CW'(1);
                    shreg <= shreg_next;
                end
            end

            // A completed frame either replaces the held character or is dropped with an overrun pulse.
            if (done) begin
                if (hold_free) begin
                    char_out   <= new_char;
                    char_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                    parity_err <= new_perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (char_valid && out_ready) begin
                char_valid <= 1'b0;
            end
        end
    end

endmodule
